data_mem_bridge: RTL and testbench
==================================

# data_mem_bridge

Multi-cycle bridge that sits directly downstream of the CPU core's data-memory port, replacing the single-cycle 32-bit data memory with an external byte-wide RAM that has a variable-latency request/acknowledge handshake. Each 32-bit word load or store from the core becomes four sequential byte transfers, most-significant byte first (big-endian).
While a transfer is in progress the bridge raises `Stall`. The core must hold PC, register-file writes and its data-port outputs while `Stall` is high.

## Interface
Parameters:
- `RAM_AW`, default 16: byte-address width on the RAM side.

Ports:
- `CLK`  in  1: system clock; all state updates on the rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `MemRead`  in  1: core requests a word load.
- `MemWrite`  in  1: core requests a word store.
- `Address`  in  32: core byte address, taken from the ALU result.
- `WriteData`  in  32: store data from the core.
- `ReadData`  out  32: assembled load data.
- `Stall`  out  1: core must not advance this cycle.
- `AlignErr`  out  1: sticky flag, set when an access has `Address[1:0]` != 0.
- `RamAddr`  out  `RAM_AW`: byte address to the RAM.
- `RamWData`  out  8: byte to write.
- `RamWe`  out  1: write qualifier, valid while `RamReq` is high.
- `RamReq`  out  1: RAM transfer request.
- `RamAck`  in  1: RAM accepts or completes the byte transfer in this cycle.
- `RamRData`  in  8: read byte, valid in the cycle `RamAck` is high.

## Operation
- FSM states: `IDLE`, `XFER`, `DONE`.
- `IDLE`:
  - `Stall = MemRead | MemWrite`, combinational.
  - If a request is present: latch the word address as `{Address[RAM_AW-1:2], 2'b00}`, latch `WriteData`, latch the operation (`MemWrite` wins if both inputs are high), clear the byte counter, then go to `XFER`.
  - If `Address[1:0]` != 0: set `AlignErr` and perform the access at the aligned address.
- `XFER`:
  - `RamReq = 1`.
  - `RamAddr = base | cnt`.
  - `RamWe` = latched write flag.
  - `RamWData` = byte `3-cnt` of the latched data, so byte 0 carries bits 31:24.
  - On `RamAck`: for a read, shift `RamRData` into the assembly register at bits `[31-8*cnt -: 8]`; then increment `cnt`.
  - When `RamAck` arrives with `cnt == 3`, go to `DONE`.
  - Without `RamAck`, hold all RAM-side outputs stable.
  - `Stall = 1`.
- `DONE`:
  - `Stall = 0`.
  - `ReadData` = assembly register (it holds its value until the next read completes).
  - Go unconditionally to `IDLE`. The core advances on this edge, so the same request is not retriggered.
- `RamAck` is ignored whenever `RamReq` is low.
- `AlignErr` is cleared only by `Reset`.

## Timing
- Reset values:
  - state `IDLE`; `cnt = 0`.
  - `ReadData = 0`; `AlignErr = 0`.
  - `RamReq = 0`, `RamWe = 0`, `RamAddr = 0`, `RamWData = 0`.
  - `Stall` follows the inputs combinationally.
- Zero-wait RAM (`RamAck` tied high): the request is seen in cycle t0, bytes transfer in t1–t4, and t5 is `DONE`. `Stall` is high for 5 cycles, so the instruction takes 6 cycles.
- Each RAM wait cycle adds one cycle of `Stall`.
- Reset mid-transfer: `RamReq` and `RamWe` drop immediately (asynchronous reset). Bytes already written remain in the RAM; no rollback.
- No request in `IDLE`: `Stall = 0` and there is no RAM activity, so non-memory instructions remain single-cycle.
- Request inputs are sampled only in `IDLE`. Changes during `XFER` or `DONE` are ignored.

## Structure
- Shared constants go in the existing CPU defines header: FSM state encodings `BRIDGE_IDLE`, `BRIDGE_XFER`, `BRIDGE_DONE`, and `BYTES_PER_WORD = 4`.
- One flat module; no sub-module is needed. The byte-lane select is an inline mux on `cnt`.
- Integration at the CPU top:
  - Gate the PC update and `RegWrite` with `!Stall`.
  - Feed `RegWriteData` from `ReadData` when `MemToReg` selects memory.

## Test plan
- Zero-wait load: RAM bytes 0x10–0x13 = 12 34 56 78; load from `Address` 0x10 → `Stall` high 5 cycles, `RamAddr` sequence 0x10, 0x11, 0x12, 0x13, `ReadData` = 0x12345678 in `DONE`.
- Store with 2 wait cycles per byte: `WriteData` 0xDEADBEEF to 0x20 → `RamWData` DE, AD, BE, EF at 0x20–0x23 with `RamWe` = 1; `Stall` high 13 cycles; RAM outputs stable during the waits.
- Misaligned load at 0x23 → accesses 0x20–0x23; `AlignErr` rises after the request and stays high through later aligned accesses until `Reset`.
- `MemRead` and `MemWrite` both high → a write is performed; `ReadData` is unchanged from its previous value.
- Reset asserted in `XFER` after 2 bytes of a store → `RamReq` low in the same cycle, state `IDLE`, bytes 0–1 modified and bytes 2–3 untouched; the next request starts again at byte 0.

Source files
------------

// File: rtl/data_mem_bridge_pkg.sv
// data_mem_bridge_pkg
//   Shared constants for the word-to-byte data-memory bridge: FSM state
//   encoding and word geometry. Imported by data_mem_bridge.
package data_mem_bridge_pkg;

  typedef enum logic [1:0] {
    BRIDGE_IDLE = 2'd0,
    BRIDGE_XFER = 2'd1,
    BRIDGE_DONE = 2'd2
  } bridge_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  // Byte counter value of the final (least-significant) byte of a word.
  localparam logic [1:0]  LAST_BYTE      = 2'(BYTES_PER_WORD - 1);

endpackage : data_mem_bridge_pkg

// File: rtl/data_mem_bridge.sv
// data_mem_bridge
//   Turns each 32-bit word load/store from the core's data port into four
//   sequential byte transfers to a byte-wide RAM with a req/ack handshake,
//   most-significant byte first. Stall holds the core until the word is done.
//
// Ports
//   CLK, Reset            clock, asynchronous active-high reset
//   MemRead, MemWrite     core word load / store request (write wins if both)
//   Address, WriteData    core byte address and store data
//   ReadData              assembled load word, held until the next load ends
//   Stall                 core must not advance this cycle
//   AlignErr              sticky, set by any access with Address[1:0] != 0
//   RamAddr, RamWData     RAM byte address and write byte
//   RamWe, RamReq         RAM write qualifier and transfer request
//   RamAck, RamRData      RAM accept/complete strobe and read byte
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int unsigned RAM_AW = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              AlignErr,
  output logic [RAM_AW-1:0] RamAddr,
  output logic [7:0]        RamWData,
  output logic              RamWe,
  output logic              RamReq,
  input  logic              RamAck,
  input  logic [7:0]        RamRData
);

  bridge_state_e     state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [RAM_AW-3:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              align_err_q, align_err_d;

  logic [7:0]        lane;
  logic [31:0]       asm_ins;

  // Address bits above the RAM window are intentionally dropped.
  generate
    if (RAM_AW < 32) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^Address[31:RAM_AW];
    end
  endgenerate

  // Big-endian byte lane select for the outgoing write byte.
  always_comb begin
    lane = '0;
    case (cnt_q)
      2'd0:    lane = wdata_q[31:24];
      2'd1:    lane = wdata_q[23:16];
      2'd2:    lane = wdata_q[15:8];
      default: lane = wdata_q[7:0];
    endcase
  end

  // Assembly register with the incoming read byte placed at its lane.
  always_comb begin
    asm_ins = asm_q;
    case (cnt_q)
      2'd0:    asm_ins[31:24] = RamRData;
      2'd1:    asm_ins[23:16] = RamRData;
      2'd2:    asm_ins[15:8]  = RamRData;
      default: asm_ins[7:0]   = RamRData;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    asm_d       = asm_q;
    rdata_d     = rdata_q;
    align_err_d = align_err_q;

    Stall    = 1'b0;
    RamReq   = 1'b0;
    RamWe    = 1'b0;
    RamAddr  = '0;
    RamWData = '0;

    case (state_q)
      BRIDGE_IDLE: begin
        Stall = MemRead | MemWrite;
        if (MemRead | MemWrite) begin
          base_d  = Address[RAM_AW-1:2];
          wdata_d = WriteData;
          is_wr_d = MemWrite;
          cnt_d   = '0;
          state_d = BRIDGE_XFER;
          if (Address[1:0] != 2'b00) begin
            align_err_d = 1'b1;
          end
        end
      end

      BRIDGE_XFER: begin
        Stall    = 1'b1;
        RamReq   = 1'b1;
        RamAddr  = {base_q, cnt_q};
        RamWe    = is_wr_q;
        RamWData = lane;
        if (RamAck) begin
          if (!is_wr_q) begin
            asm_d = asm_ins;
          end
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_BYTE) begin
            state_d = BRIDGE_DONE;
            // Publish the completed word on the final byte so ReadData is
            // already valid during DONE; writes leave it untouched.
            if (!is_wr_q) begin
              rdata_d = asm_ins;
            end
          end
        end
      end

      BRIDGE_DONE: begin
        state_d = BRIDGE_IDLE;
      end

      default: begin
        state_d = BRIDGE_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= BRIDGE_IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      asm_q       <= '0;
      rdata_q     <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      asm_q       <= asm_d;
      rdata_q     <= rdata_d;
      align_err_q <= align_err_d;
    end
  end

  assign ReadData = rdata_q;
  assign AlignErr = align_err_q;

endmodule : data_mem_bridge

// File: tb/tb_data_mem_bridge.sv
module tb_data_mem_bridge;

  logic        CLK;
  logic        Reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        AlignErr;
  logic [15:0] RamAddr;
  logic [7:0]  RamWData;
  logic        RamWe;
  logic        RamReq;
  logic        RamAck;
  logic [7:0]  RamRData;

  data_mem_bridge #(.RAM_AW(16)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Address  (Address),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .Stall    (Stall),
    .AlignErr (AlignErr),
    .RamAddr  (RamAddr),
    .RamWData (RamWData),
    .RamWe    (RamWe),
    .RamReq   (RamReq),
    .RamAck   (RamAck),
    .RamRData (RamRData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Byte RAM model with a configurable number of wait cycles per byte.
  logic [7:0] mem [0:65535];
  int         wait_cfg;
  int         wcnt;

  assign RamAck   = RamReq && (wcnt == wait_cfg);
  assign RamRData = mem[RamAddr];

  always @(posedge CLK or posedge Reset) begin
    if (Reset)               wcnt <= 0;
    else if (RamReq && !RamAck) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [31:0] rd_q[$];
  int          n_checks;
  int          n_fail;
  logic        held;
  logic [24:0] held_v;
  logic [31:0] last_read;

  // Pops the byte-transfer scoreboard on every accepted RAM transfer and
  // checks that RAM outputs stay put across wait cycles.
  task automatic scoreboard_step();
    xfer_t e;
    if (RamReq) begin
      if (held) begin
        n_checks++;
        if ({RamAddr, RamWe, RamWData} !== held_v) begin
          n_fail++;
          $display("FAIL ram_stable: got %h required %h", {RamAddr, RamWe, RamWData}, held_v);
        end
      end
      if (RamAck) begin
        held = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ram_unexpected: got addr %h we %b", RamAddr, RamWe);
        end else begin
          e = exp_q.pop_front();
          if (RamAddr !== e.addr || RamWe !== e.we || (e.we && RamWData !== e.wdata)) begin
            n_fail++;
            $display("FAIL ram_xfer: got addr %h we %b wd %h required addr %h we %b wd %h",
                     RamAddr, RamWe, RamWData, e.addr, e.we, e.wdata);
          end
        end
        if (RamWe) mem[RamAddr] = RamWData;
      end else begin
        held   = 1'b1;
        held_v = {RamAddr, RamWe, RamWData};
      end
    end else begin
      held = 1'b0;
    end
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int wt,
                           input logic [31:0] exp_rd, input int exp_stall, input string tag);
    xfer_t       e;
    logic [15:0] base;
    logic [31:0] got_exp;
    int          stall_cnt;
    int          cycles;
    base = {addr[15:2], 2'b00};
    for (int i = 0; i < 4; i++) begin
      e.addr  = base + 16'(i);
      e.we    = wr;
      e.wdata = wdata[31 - 8*i -: 8];
      exp_q.push_back(e);
    end
    rd_q.push_back(exp_rd);
    @(negedge CLK);
    wait_cfg  = wt;
    MemRead   = rd;
    MemWrite  = wr;
    Address   = addr;
    WriteData = wdata;
    #1;
    stall_cnt = 0;
    cycles    = 0;
    while (Stall && cycles < 200) begin
      stall_cnt++;
      @(negedge CLK);
      scoreboard_step();
      cycles++;
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    n_checks++;
    if (cycles >= 200) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d cycles required fewer than 200", tag, cycles);
    end else if (stall_cnt !== exp_stall) begin
      n_fail++;
      $display("FAIL %s_stall: got %0d required %0d", tag, stall_cnt, exp_stall);
    end
    got_exp = rd_q.pop_front();
    n_checks++;
    if (ReadData !== got_exp) begin
      n_fail++;
      $display("FAIL %s_rdata: got %h required %h", tag, ReadData, got_exp);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: got %0d bytes left required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_word(input logic [15:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] got;
    got = {mem[a], mem[a+16'd1], mem[a+16'd2], mem[a+16'd3]};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({ReadData, AlignErr, RamReq, RamWe, RamAddr, RamWData, Stall} !== 60'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd %h ae %b req %b we %b addr %h wd %h st %b required all zero",
               ReadData, AlignErr, RamReq, RamWe, RamAddr, RamWData, Stall);
    end
    MemRead = 1'b1;
    #1;
    n_checks++;
    if (Stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall_comb: got %b required 1", Stall);
    end
    MemRead = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic test_zero_wait_load();
    mem[16'h10] = 8'h12; mem[16'h11] = 8'h34; mem[16'h12] = 8'h56; mem[16'h13] = 8'h78;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h12345678, 5, "zw_load");
    last_read = 32'h12345678;
  endtask

  task automatic test_wait_store();
    do_access(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 2, last_read, 13, "wait_store");
    check_word(16'h20, 32'hDEADBEEF, "wait_store_mem");
  endtask

  task automatic test_misaligned();
    n_checks++;
    if (AlignErr !== 1'b0) begin
      n_fail++;
      $display("FAIL align_before: got %b required 0", AlignErr);
    end
    do_access(1'b1, 1'b0, 32'h23, 32'h0, 0, 32'hDEADBEEF, 5, "misalign_load");
    last_read = 32'hDEADBEEF;
    n_checks++;
    if (AlignErr !== 1'b1) begin
      n_fail++;
      $display("FAIL align_set: got %b required 1", AlignErr);
    end
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'h12345678, 9, "aligned_after");
    last_read = 32'h12345678;
    n_checks++;
    if (AlignErr !== 1'b1) begin
      n_fail++;
      $display("FAIL align_sticky: got %b required 1", AlignErr);
    end
  endtask

  task automatic test_both_high();
    do_access(1'b1, 1'b1, 32'h30, 32'h0BADCAFE, 0, last_read, 5, "both_high");
    check_word(16'h30, 32'h0BADCAFE, "both_high_mem");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    int          wt;
    for (int n = 0; n < 10; n++) begin
      a  = 32'h100 + 32'($urandom_range(0, 63)) * 4;
      wt = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        do_access(1'b0, 1'b1, a, d, wt, last_read, 1 + 4 * (wt + 1), "b2b_store");
      end else begin
        exp = {mem[a[15:0]], mem[a[15:0]+16'd1], mem[a[15:0]+16'd2], mem[a[15:0]+16'd3]};
        do_access(1'b1, 1'b0, a, 32'h0, wt, exp, 1 + 4 * (wt + 1), "b2b_load");
        last_read = exp;
      end
    end
  endtask

  task automatic test_reset_mid();
    xfer_t e;
    mem[16'h40] = 8'h11; mem[16'h41] = 8'h22; mem[16'h42] = 8'h33; mem[16'h43] = 8'h44;
    e.we = 1'b1;
    e.addr = 16'h40; e.wdata = 8'hCA; exp_q.push_back(e);
    e.addr = 16'h41; e.wdata = 8'hFE; exp_q.push_back(e);
    @(negedge CLK);
    wait_cfg  = 0;
    MemWrite  = 1'b1;
    Address   = 32'h40;
    WriteData = 32'hCAFEF00D;
    repeat (2) begin
      @(negedge CLK);
      scoreboard_step();
    end
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    n_checks++;
    if (RamReq !== 1'b0 || RamWe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_drop: got req %b we %b required 0 0", RamReq, RamWe);
    end
    MemWrite = 1'b0;
    held     = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_bytes: got %0d bytes left required 0", exp_q.size());
      exp_q.delete();
    end
    check_word(16'h40, 32'hCAFE3344, "reset_mid_mem");
    @(negedge CLK);
    Reset = 1'b0;
    n_checks++;
    if (AlignErr !== 1'b0 || ReadData !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got ae %b rd %h required 0 0", AlignErr, ReadData);
    end
    last_read = 32'h0;
    do_access(1'b0, 1'b1, 32'h40, 32'h55667788, 1, last_read, 9, "restart_store");
    check_word(16'h40, 32'h55667788, "restart_mem");
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 0, 32'h55667788, 5, "restart_load");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    held      = 1'b0;
    held_v    = '0;
    last_read = 32'h0;
    wait_cfg  = 0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = 32'h0;
    WriteData = 32'h0;
    Reset     = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);

    test_reset();
    test_zero_wait_load();
    test_wait_store();
    test_misaligned();
    test_both_high();
    test_back_to_back();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_data_mem_bridge
